// File: rtl/text_sequencer_pkg.sv
// Shared definitions for the text sequencer: letter encoding, message ROM and
// sequencer state type.
package text_defs;

    localparam logic [3:0] LETTER_BLANK = 4'hF;

    // Letter encoding shared with the letter renderer.
    localparam logic [3:0] LETTER_A = 4'h0;
    localparam logic [3:0] LETTER_D = 4'h1;
    localparam logic [3:0] LETTER_E = 4'h2;
    localparam logic [3:0] LETTER_G = 4'h3;
    localparam logic [3:0] LETTER_M = 4'h4;
    localparam logic [3:0] LETTER_O = 4'h5;
    localparam logic [3:0] LETTER_R = 4'h6;
    localparam logic [3:0] LETTER_V = 4'h7;
    localparam logic [3:0] LETTER_Y = 4'h8;

    localparam int NUM_MSGS  = 4;
    localparam int MSG_SLOTS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REVEAL = 2'd1,
        HOLD   = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    // Message 0 is intentionally empty so a freshly reset sequencer shows blanks.
    localparam logic [3:0] MSG_LEN [NUM_MSGS] = '{4'd0, 4'd2, 4'd5, 4'd8};

    localparam logic [3:0] MSG_ROM [NUM_MSGS][MSG_SLOTS] = '{
        '{LETTER_BLANK, LETTER_BLANK, LETTER_BLANK, LETTER_BLANK,
          LETTER_BLANK, LETTER_BLANK, LETTER_BLANK, LETTER_BLANK},
        '{LETTER_G, LETTER_O, LETTER_BLANK, LETTER_BLANK,
          LETTER_BLANK, LETTER_BLANK, LETTER_BLANK, LETTER_BLANK},
        '{LETTER_R, LETTER_E, LETTER_A, LETTER_D,
          LETTER_Y, LETTER_BLANK, LETTER_BLANK, LETTER_BLANK},
        '{LETTER_G, LETTER_A, LETTER_M, LETTER_E,
          LETTER_O, LETTER_V, LETTER_E, LETTER_R}
    };

    function automatic logic [7:0] frames_to_term(input int frames);
        return 8'(frames - 1);
    endfunction

endpackage

// File: rtl/text_sequencer_frame_timer.sv
// Frame-pulse counter with a runtime terminal value; pulses terminal on the
// tick that matches it and wraps to zero. Synchronous clear wins over tick.
module frame_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic [7:0] term,
    output logic       terminal
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        terminal = tick && !clear && (count_q == term);
        count_d  = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = terminal ? 8'd0 : count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/text_sequencer.sv
// Sequences a ROM message onto the letter renderer: frame-paced reveal, hold
// with optional blink, then a one-cycle done pulse.
//   state  | meaning
//   IDLE   | ready for a request, nothing shown
//   REVEAL | one more letter every REVEAL_FRAMES frame pulses
//   HOLD   | whole message up for HOLD_FRAMES pulses, blinking if enabled
//   FINISH | single cycle, done asserted
module text_sequencer
    import text_defs::*;
#(
    parameter int MAX_LETTERS   = 8,
    parameter int REVEAL_FRAMES = 6,
    parameter int HOLD_FRAMES   = 120,
    parameter int BLINK_FRAMES  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       msgValid,
    input  logic [1:0] msgId,
    output logic       msgReady,
    input  logic       clearReq,
    input  logic [2:0] slotIndex,
    output logic [3:0] letterCode,
    output logic       slotVisible,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] REVEAL_TERM = frames_to_term(REVEAL_FRAMES);
    localparam logic [7:0] HOLD_TERM   = frames_to_term(HOLD_FRAMES);
    localparam logic [7:0] BLINK_TERM  = frames_to_term(BLINK_FRAMES);
    localparam logic       BLINK_EN    = (BLINK_FRAMES != 0);
    localparam logic [3:0] SLOT_LIMIT  = 4'(MAX_LETTERS);

    seq_state_t state_q, state_d;
    logic [1:0] latched_id_q, latched_id_d;
    logic [3:0] reveal_count_q, reveal_count_d;
    logic       blink_on_q, blink_on_d;
    logic       msg_ready_q, msg_ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       accept;
    logic       timing_active;
    logic       frame_clear, frame_tick, frame_tc;
    logic [7:0] frame_term;
    logic       blink_clear, blink_tick, blink_tc;
    logic [3:0] next_reveal;
    logic [3:0] slot_ext;
    logic       slot_in_msg;

    assign accept        = msgValid && msg_ready_q && !clearReq;
    assign timing_active = (state_q == REVEAL) || (state_q == HOLD);

    // One timer serves both REVEAL and HOLD; it wraps to zero on the reveal
    // terminal, so HOLD always starts from a fresh count.
    assign frame_clear = clearReq || !timing_active;
    assign frame_tick  = startOfFrame && timing_active;
    assign frame_term  = (state_q == REVEAL) ? REVEAL_TERM : HOLD_TERM;

    frame_timer u_frame_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (frame_clear),
        .tick     (frame_tick),
        .term     (frame_term),
        .terminal (frame_tc)
    );

    assign blink_clear = clearReq || (state_q != HOLD);
    assign blink_tick  = startOfFrame && (state_q == HOLD) && BLINK_EN;

    frame_timer u_blink_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (blink_clear),
        .tick     (blink_tick),
        .term     (BLINK_TERM),
        .terminal (blink_tc)
    );

    assign next_reveal = reveal_count_q + 4'd1;

    always_comb begin
        state_d        = state_q;
        latched_id_d   = latched_id_q;
        reveal_count_d = reveal_count_q;
        blink_on_d     = blink_on_q;

        if (clearReq) begin
            state_d        = IDLE;
            reveal_count_d = '0;
            blink_on_d     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        latched_id_d   = msgId;
                        reveal_count_d = '0;
                        blink_on_d     = 1'b1;
                        state_d        = (MSG_LEN[msgId] == 4'd0) ? FINISH : REVEAL;
                    end
                end
                REVEAL: begin
                    if (frame_tc) begin
                        reveal_count_d = next_reveal;
                        if (next_reveal == MSG_LEN[latched_id_q]) begin
                            state_d    = HOLD;
                            blink_on_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (blink_tc) begin
                        blink_on_d = !blink_on_q;
                    end
                    if (frame_tc) begin
                        state_d = FINISH;
                    end
                end
                FINISH: begin
                    state_d        = IDLE;
                    reveal_count_d = '0;
                    blink_on_d     = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        msg_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            latched_id_q   <= '0;
            reveal_count_q <= '0;
            blink_on_q     <= 1'b1;
            msg_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            latched_id_q   <= latched_id_d;
            reveal_count_q <= reveal_count_d;
            blink_on_q     <= blink_on_d;
            msg_ready_q    <= msg_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Pixel path: combinational from registered state so the renderer sees
    // the slot answer in the same cycle it presents slotIndex.
    assign slot_ext    = {1'b0, slotIndex};
    assign slot_in_msg = (slot_ext < MSG_LEN[latched_id_q]) && (slot_ext < SLOT_LIMIT);

    assign letterCode  = slot_in_msg ? MSG_ROM[latched_id_q][slotIndex] : LETTER_BLANK;
    assign slotVisible = timing_active && (slot_ext < reveal_count_q) &&
                         (slot_ext < SLOT_LIMIT) && blink_on_q;

    assign msgReady = msg_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
